// File: rtl/anubis_dec_key_sched.sv
// Anubis decryption key scheduler: buffers the R+1 encryption round keys, then streams them
// back in reverse order with theta applied to every inner key.
module anubis_dec_key_sched #(
    parameter int unsigned NUM_ROUNDS = 12,
    parameter int unsigned IDX_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_key,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned PtrW = $clog2(NUM_ROUNDS + 1);
    localparam logic [IDX_W-1:0] RIdx = IDX_W'(NUM_ROUNDS);

    if ((2 ** IDX_W) <= NUM_ROUNDS) begin : g_bad_idx_w
        $error("IDX_W too narrow for NUM_ROUNDS");
    end

    typedef enum logic [1:0] {
        StLoad,
        StEmit,
        StDrain
    } state_e;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [31:0] theta_row(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        r0 = xtime(a1 ^ a3);
        r1 = xtime(a0 ^ a2);
        r2 = xtime(xtime(a2 ^ a3));
        r3 = xtime(xtime(a0 ^ a1));
        return {a0 ^ r0 ^ r2, a1 ^ r1 ^ r2, a2 ^ r0 ^ r3, a3 ^ r1 ^ r3};
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] k);
        logic [127:0] res;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            res[127-32*j -: 32] = theta_row(k[127-32*j -: 32]);
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   rp_q, rp_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       out_key_q, out_key_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               wr_en;
    logic [127:0]       rd_key;
    logic [127:0]       buf_q [NUM_ROUNDS+1];

    assign rd_key = buf_q[rp_q[PtrW-1:0]];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rp_d        = rp_q;
        out_valid_d = out_valid_q;
        out_key_d   = out_key_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        wr_en       = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (count_q == RIdx) begin
                        count_d = '0;
                        rp_d    = RIdx;
                        state_d = StEmit;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StEmit: begin
                // Loading in the same cycle as the handshake keeps the stream bubble-free.
                if (!out_valid_q || out_ready) begin
                    out_key_d   = (rp_q == RIdx || rp_q == '0) ? rd_key : theta(rd_key);
                    out_idx_d   = RIdx - rp_q;
                    out_last_d  = (rp_q == '0);
                    out_valid_d = 1'b1;
                    if (rp_q == '0) begin
                        state_d = StDrain;
                    end else begin
                        rp_d = rp_q - 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            count_q     <= '0;
            rp_q        <= '0;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rp_q        <= rp_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    // Key storage needs no reset; it is always fully rewritten before being read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[count_q[PtrW-1:0]] <= in_key;
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StLoad) || (count_q != '0);

endmodule

// File: tb/tb_anubis_dec_key_sched.sv
// Directed bench for anubis_dec_key_sched: ordering, theta, reduction, stalls, reset, back-to-back.
module tb_anubis_dec_key_sched;

    localparam int unsigned R     = 12;
    localparam int unsigned IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_key;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_key;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] kin  [R+1];
    logic [127:0] kexp [R+1];

    anubis_dec_key_sched #(
        .NUM_ROUNDS(R),
        .IDX_W     (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_key  (out_key),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Order/theta pattern: inner keys 01000000 rows map to 01020406 rows.
    task automatic fill_order();
        kin[0]  = {16{8'hAA}};
        kin[R]  = {16{8'h55}};
        for (int i = 1; i < R; i++) kin[i] = {4{32'h01000000}};
        kexp[0] = {16{8'h55}};
        kexp[R] = {16{8'hAA}};
        for (int i = 1; i < R; i++) kexp[i] = {4{32'h01020406}};
    endtask

    // Involution pattern: inner keys 01020406 rows map back to 01000000 rows.
    task automatic fill_invol();
        kin[0]  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        kin[R]  = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        for (int i = 1; i < R; i++) kin[i] = {4{32'h01020406}};
        kexp[0] = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        kexp[R] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        for (int i = 1; i < R; i++) kexp[i] = {4{32'h01000000}};
    endtask

    // Reduction pattern: an 80 byte walks across each row position in K5..K2.
    task automatic fill_reduce();
        for (int i = 0; i <= R; i++) begin
            kin[i]  = '0;
            kexp[i] = '0;
        end
        kin[0]   = 128'hDEADBEEF_00000001_00000002_00000003;
        kin[R]   = 128'hCAFEF00D_10000000_20000000_30000000;
        kin[5]   = 128'h80000000_00000000_00000000_00000000;
        kin[4]   = 128'h00000000_80000000_00000000_00000000;
        kin[3]   = 128'h00000000_00000000_80000000_00000000;
        kin[2]   = 128'h00000000_00000000_00000000_80000000;
        kexp[0]  = 128'hCAFEF00D_10000000_20000000_30000000;
        kexp[R]  = 128'hDEADBEEF_00000001_00000002_00000003;
        kexp[7]  = 128'h801D3A27_00000000_00000000_00000000;
        kexp[8]  = 128'h00000000_801D3A27_00000000_00000000;
        kexp[9]  = 128'h00000000_00000000_801D3A27_00000000;
        kexp[10] = 128'h00000000_00000000_00000000_801D3A27;
    endtask

    task automatic load(input bit keep_valid);
        for (int i = 0; i <= R; i++) begin
            in_valid = 1'b1;
            in_key   = kin[i];
            chk("load_in_ready", {127'd0, in_ready}, 128'd1);
            step();
        end
        chk("post_load_in_ready", {127'd0, in_ready}, 128'd0);
        chk("post_load_out_valid", {127'd0, out_valid}, 128'd0);
        chk("post_load_busy", {127'd0, busy}, 128'd1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic recv(input bit rnd);
        int           n;
        int           cyc;
        bit           stalled;
        logic [127:0] pk;
        logic [IDX_W-1:0] pi;
        logic         pl;
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        pk = '0;
        pi = '0;
        pl = 1'b0;
        while (n <= R && cyc < 400) begin
            if (stalled) begin
                chk("stall_key", out_key, pk);
                chk("stall_idx", {123'd0, out_idx}, {123'd0, pi});
                chk("stall_last", {127'd0, out_last}, {127'd0, pl});
            end
            chk("emit_in_ready", {127'd0, in_ready}, 128'd0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                chk($sformatf("key%0d", n), out_key, kexp[n]);
                chk($sformatf("idx%0d", n), {123'd0, out_idx}, 128'(n));
                chk($sformatf("last%0d", n), {127'd0, out_last}, {127'd0, n == R});
                n++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                pk = out_key;
                pi = out_idx;
                pl = out_last;
            end else begin
                stalled = 1'b0;
            end
            step();
            cyc++;
        end
        chk("recv_count", 128'(n), 128'(R + 1));
        if (!rnd) chk("recv_cycles", 128'(cyc), 128'(R + 2));
        chk("drain_out_valid", {127'd0, out_valid}, 128'd0);
        chk("drain_in_ready", {127'd0, in_ready}, 128'd1);
        chk("drain_busy", {127'd0, busy}, 128'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_key", out_key, 128'd0);
        chk("rst_out_idx", {123'd0, out_idx}, 128'd0);
        chk("rst_out_last", {127'd0, out_last}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Ordering and theta on inner keys, full-rate drain.
        fill_order();
        load(1'b0);
        recv(1'b0);

        // theta is its own inverse.
        fill_invol();
        load(1'b0);
        recv(1'b0);

        // Reduction polynomial in every row position, random backpressure.
        fill_reduce();
        load(1'b0);
        recv(1'b1);

        // Asynchronous reset in the middle of EMIT.
        fill_order();
        load(1'b0);
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("pre_rst_out_valid", {127'd0, out_valid}, 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_out_idx", {123'd0, out_idx}, 128'd0);
        chk("mid_rst_out_key", out_key, 128'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fill_invol();
        load(1'b0);
        recv(1'b1);

        // Back-to-back with in_valid held high; the next K0 is presented during EMIT/DRAIN.
        fill_reduce();
        load(1'b1);
        in_key = {16{8'hAA}};
        recv(1'b0);
        fill_order();
        load(1'b0);
        recv(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/anubis_dec_key_sched.md
Name: anubis_dec_key_sched

Overview:
Converts the encryption round-key sequence K0..KR of the Anubis cipher into the decryption round-key sequence. The decryption keys are K'0=KR, K'r=theta(K(R-r)) for 0<r<R, and K'R=K0. The block sits between the key-expansion unit and the decryption datapath. It buffers all R+1 encryption keys, then streams them out in reverse order, applying theta (the H-matrix row multiply) to the inner keys.

Parameters:
NUM_ROUNDS, 12, number of rounds R (8+N; 12 for 128-bit key, max 18); buffer depth = R+1
IDX_W, 5, width of key index outputs; must satisfy 2^IDX_W > NUM_ROUNDS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  encryption round key present on in_key
in_ready  output  1  block accepts in_key this cycle
in_key  input  128  encryption round key; keys arrive in order K0 first
out_valid  output  1  decryption round key present on out_key
out_ready  input  1  downstream accepts out_key this cycle
out_key  output  128  decryption round key K'i
out_idx  output  IDX_W  decryption key index i, 0..R
out_last  output  1  high with K'R
busy  output  1  high whenever state is not LOAD or count != 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), applied on the falling edge of rst_n and released synchronously.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_key=0, out_idx=0, out_last=0, busy=0, load count=0. Buffer contents are don't-care.
- Key layout: 128 bits = 4 rows x 4 bytes.
  - Row j occupies [127-32j -: 32].
  - Byte a0 is the MSB byte of the row.
- theta, applied per row independently:
  - xtime(v) = v<<1, XORed with 8'h1D when v[7]=1 (polynomial x^8+x^4+x^3+x^2+1).
  - r0=xtime(a1^a3), r1=xtime(a0^a2), r2=xtime(xtime(a2^a3)), r3=xtime(xtime(a0^a1)).
  - b0=a0^r0^r2, b1=a1^r1^r2, b2=a2^r0^r3, b3=a3^r1^r3.
  - theta is an involution.
- State LOAD:
  - in_ready=1.
  - Each in_valid&in_ready cycle writes in_key to buf[count] and increments count.
  - When the write with count==R occurs, count clears and the next state is EMIT.
  - out_valid=0 throughout LOAD.
- State EMIT:
  - in_ready=0; in_valid is ignored.
  - Read pointer rp starts at R and decrements once per output load.
  - The output register is loaded when (!out_valid || out_ready):
    - out_key = buf[rp] when rp==R or rp==0, otherwise theta(buf[rp]).
    - out_idx = R-rp; out_last = (rp==0); out_valid=1.
  - After the rp==0 entry is loaded, the next state is DRAIN.
- State DRAIN:
  - Holds the last key until out_ready.
  - On the accepting handshake, out_valid=0, out_last=0, next state LOAD.
  - in_ready rises the cycle after that handshake.
- Latency: last input accepted at edge t → out_valid=1 with K'0 after edge t+1. With out_ready held high, one key per cycle: R+1 output cycles, followed by 1 LOAD turnaround cycle.
- Stall: while out_valid & !out_ready, out_key, out_idx and out_last hold stable, and rp does not move.
- No output bubbles: a handshake and the load of the next key occur in the same cycle.
- Reset mid-operation (any state): immediate return to reset values; partially loaded or partially emitted sequences are discarded.
- in_valid asserted during EMIT/DRAIN: no effect, no buffer write.
- theta logic is purely combinational on the buffer read path; there is a single output register stage.

Test Plan:
- Reset: assert rst_n=0 mid-EMIT → out_valid=0, in_ready=1, count=0 asynchronously; a fresh load of 13 keys works normally.
- Order/theta, R=12: load Ki = 128'h01000000_01000000_01000000_01000000 for i=1..11, K0=all 8'hAA, K12=all 8'h55, out_ready=1.
  - Expected out: idx0=all 55; idx1..11 = 128'h01020406_01020406_01020406_01020406; idx12=all AA with out_last=1.
  - out_valid rises one cycle after the 13th input handshake.
- Involution: load Ki = 128'h01020406 repeated 4x for i=1..11 → inner outputs = 128'h01000000 repeated 4x.
- Reduction: a row 80000000 in K5 → K'7 row = 80,1D,3A,27 (bytes b0..b3); check for all four row positions.
- Backpressure: randomly toggle out_ready → every key stays stable while stalled; indices 0..12 appear exactly once each; in_ready stays 0 until out_last is accepted.
- Back-to-back: two full sequences with in_valid held high → in_ready=0 during EMIT/DRAIN; the second sequence's keys are not written early; the second output sequence is correct.
